// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the load/store stage and memory
interface mem_access_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store stage: one req/ack access, load writeback, bus timeout fault
// Optional pointer post-increment through the register-file pair adder when POST_INC_EN is defined.
module mem_access_stage #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [3:0]        ptr_sel,
  input  logic [DATA_W-1:0] ptr_hi,
  input  logic [DATA_W-1:0] ptr_lo,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        dst_sel,
  input  logic [DATA_W-1:0] inc_const,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              rf_write_en,
  output logic              rf_add,
  output logic [3:0]        rf_a_select,
  output logic [DATA_W-1:0] rf_din,
  output logic [DATA_W-1:0] rf_constant,
  mem_access_stage_if.master mem
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

`ifdef POST_INC_EN
  typedef enum logic [1:0] {IDLE, REQ, WB, INC} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
`endif

  state_t            state;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        dst_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              fault_q;

  logic   in_req;
  logic   ack_hit;
  logic   timeout_hit;
  logic   post_inc;
  state_t after_ok;

`ifdef POST_INC_EN
  logic [2:0]        pair_q;
  logic [DATA_W-1:0] inc_q;
  logic              unused_bits;

  assign post_inc    = (inc_q != '0);
  assign after_ok    = post_inc ? INC : IDLE;
  assign unused_bits = ptr_sel[0];
`else
  logic unused_bits;

  assign post_inc    = 1'b0;
  assign after_ok    = IDLE;
  assign unused_bits = ^{ptr_sel, inc_const};
`endif

  assign in_req      = (state == REQ);
  assign ack_hit     = in_req && mem.mem_ack;
  // An ack arriving in the last allowed cycle still counts as success.
  assign timeout_hit = in_req && !mem.mem_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dst_q   <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
`ifdef POST_INC_EN
      pair_q  <= '0;
      inc_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            store_q <= is_store;
            addr_q  <= ADDR_W'({ptr_hi, ptr_lo});
            wdata_q <= st_data;
            dst_q   <= dst_sel;
            cnt     <= '0;
            fault_q <= 1'b0;
`ifdef POST_INC_EN
            pair_q  <= ptr_sel[3:1];
            inc_q   <= inc_const;
`endif
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (!store_q) begin
              rdata_q <= mem.mem_rdata;
              state   <= WB;
            end else begin
              state   <= after_ok;
            end
          end else if (cnt == CNT_LAST) begin
            fault_q <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WB: state <= after_ok;
`ifdef POST_INC_EN
        INC: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign fault = fault_q | timeout_hit;

  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & store_q;
  assign mem.mem_addr  = in_req ? addr_q : '0;
  assign mem.mem_wdata = in_req ? wdata_q : '0;

  assign rf_write_en = (state == WB);
  assign rf_din      = (state == WB) ? rdata_q : '0;

`ifdef POST_INC_EN
  assign done        = (ack_hit && store_q && !post_inc) || timeout_hit ||
                       ((state == WB) && !post_inc) || (state == INC);
  assign rf_add      = (state == INC);
  assign rf_constant = (state == INC) ? inc_q : '0;
  assign rf_a_select = (state == WB)  ? dst_q :
                       (state == INC) ? {pair_q, 1'b0} : 4'd0;
`else
  assign done        = (ack_hit && store_q) || timeout_hit || (state == WB);
  assign rf_add      = 1'b0;
  assign rf_constant = '0;
  assign rf_a_select = (state == WB) ? dst_q : 4'd0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench for mem_access_stage with a latency-window model and register-file model
// Expectations follow POST_INC_EN when it is defined for the build.
module tb_mem_access_stage;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset, start, is_store;
  logic [3:0] ptr_sel, dst_sel;
  logic [7:0] ptr_hi, ptr_lo, st_data, inc_const;
  logic       busy, done, fault, rf_write_en, rf_add;
  logic [3:0] rf_a_select;
  logic [7:0] rf_din, rf_constant;

  mem_access_stage_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_access_stage #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .ptr_sel(ptr_sel), .ptr_hi(ptr_hi), .ptr_lo(ptr_lo), .st_data(st_data),
    .dst_sel(dst_sel), .inc_const(inc_const), .busy(busy), .done(done),
    .fault(fault), .rf_write_en(rf_write_en), .rf_add(rf_add),
    .rf_a_select(rf_a_select), .rf_din(rf_din), .rf_constant(rf_constant),
    .mem(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int mreq_cnt = 0, last_done_cyc = -1;

  // Current access plan: start cycle, ack/timeout cycle, final cycle.
  int         p_s = 0, p_a = 0, p_e = 0;
  bit         p_active = 0, p_load = 0, p_to = 0, p_pi = 0, prev_fault = 0;
  logic [15:0] p_ptr;
  logic [7:0]  p_wdata, p_rdata, p_inc;
  logic [3:0]  p_dst, p_pair;

  logic [7:0] regs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_image(input int i);
    case (i)
      2, 3:    return 8'hFF;
      10:      return 8'h10;
      11:      return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  task automatic compare_cycle();
    bit ereq, ebusy, edone, ewb, einc, efault;
    logic [3:0]  esel;
    logic [15:0] pair;
    int c;
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_rf_write_en", rf_write_en, 0);
      chk("rst_rf_add", rf_add, 0);
      chk("rst_rf_a_select", rf_a_select, 0);
      for (int i = 0; i < 16; i++) regs[i] = reg_image(i);
      return;
    end
    c      = cyc;
    ereq   = p_active && c >= p_s + 1 && c <= p_a;
    ebusy  = p_active && c >= p_s + 1 && c <= p_e;
    edone  = p_active && c == p_e;
    ewb    = p_active && p_load && !p_to && c == p_a + 1;
    einc   = p_active && p_pi && !p_to && c == p_e;
    efault = (p_active && p_to && c >= p_a) || (prev_fault && c <= p_s);
    esel   = ewb ? p_dst : (einc ? p_pair : 4'd0);
    chk("busy", busy, ebusy);
    chk("done", done, edone);
    chk("fault", fault, efault);
    chk("mem_req", bus.mem_req, ereq);
    chk("rf_write_en", rf_write_en, ewb);
    chk("rf_add", rf_add, einc);
    chk("rf_a_select", rf_a_select, esel);
    if (ereq) begin
      chk("mem_we", bus.mem_we, !p_load);
      chk("mem_addr", bus.mem_addr, p_ptr);
      if (!p_load) chk("mem_wdata", bus.mem_wdata, p_wdata);
    end
    if (ewb)  chk("rf_din", rf_din, p_rdata);
    if (einc) chk("rf_constant", rf_constant, p_inc);
    if (bus.mem_req) mreq_cnt++;
    if (done) last_done_cyc = c;
    if (rf_write_en) regs[rf_a_select] = rf_din;
    if (rf_add) begin
      pair = {regs[{rf_a_select[3:1], 1'b1}], regs[{rf_a_select[3:1], 1'b0}]}
             + {{8{rf_constant[7]}}, rf_constant};
      regs[{rf_a_select[3:1], 1'b1}] = pair[15:8];
      regs[{rf_a_select[3:1], 1'b0}] = pair[7:0];
    end
  endtask

  always @(negedge clk) compare_cycle();

  // Called at posedge+1; returns at posedge+1 of the cycle after done (or after reset release).
  task automatic access(input bit st, input logic [15:0] ptr, input logic [7:0] wd,
                        input logic [3:0] dst, input logic [3:0] psel, input logic [7:0] inc,
                        input int d, input logic [7:0] rd, input int spur, input int rst_at);
    prev_fault = p_active && p_to;
    p_s = cyc; p_load = !st; p_ptr = ptr; p_wdata = wd; p_rdata = rd;
    p_dst = dst; p_pair = {psel[3:1], 1'b0}; p_inc = inc;
`ifdef POST_INC_EN
    p_pi = (inc != 8'h00);
`else
    p_pi = 1'b0;
`endif
    p_to = (d < 0);
    p_a  = p_to ? p_s + TO : p_s + 1 + d;
    p_e  = p_to ? p_a : p_a + (p_load ? 1 : 0) + (p_pi ? 1 : 0);
    p_active = 1;
    is_store = st; ptr_hi = ptr[15:8]; ptr_lo = ptr[7:0]; st_data = wd;
    dst_sel = dst; ptr_sel = psel; inc_const = inc; start = 1'b1;
    for (int c = p_s + 1; c <= p_e; c++) begin
      @(posedge clk); #1;
      start = (spur > 0 && c == p_s + spur);
      if (c == p_s + 1) begin
        ptr_hi = ~ptr_hi; ptr_lo = ptr_lo ^ 8'h5A; st_data = ~st_data;
        dst_sel = ~dst_sel; ptr_sel = ~ptr_sel; inc_const = 8'h7F; is_store = ~is_store;
      end
      bus.mem_ack   = (!p_to && c == p_a);
      bus.mem_rdata = bus.mem_ack ? rd : 8'hEE;
      if (rst_at > 0 && c == p_s + rst_at) begin
        #1 reset = 1'b0;
        #1;
        chk("abort_mem_req", bus.mem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        p_active = 0; prev_fault = 0; start = 1'b0; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'hEE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; is_store = 1'b0; ptr_sel = 0; dst_sel = 0;
    ptr_hi = 0; ptr_lo = 0; st_data = 0; inc_const = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_mem_addr", bus.mem_addr, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;

    // Load 0x1234 -> r5, ack on the 4th REQ cycle.
    access(0, 16'h1234, 8'h00, 4'd5, 4'd0, 8'h00, 3, 8'hA5, 0, 0);
    chk("load_r5", regs[5], 8'hA5);
    chk("load_latency", last_done_cyc - p_s, 5);
    chk("load_fault", fault, 0);

    // Back-to-back store, ack in first REQ cycle.
    access(1, 16'h00FF, 8'h3C, 4'd6, 4'd0, 8'h00, 0, 8'h00, 0, 0);
    chk("store_latency", last_done_cyc - p_s, 1);
    chk("store_r6_untouched", regs[6], 8'h00);

    // Timeout with a spurious start while busy.
    mreq_cnt = 0;
    access(0, 16'hBEEF, 8'h00, 4'd7, 4'd0, 8'h00, -1, 8'h00, 5, 0);
    chk("timeout_req_cycles", mreq_cnt, 64);
    chk("timeout_fault_sticky", fault, 1);
    chk("timeout_no_wb", regs[7], 8'h00);

    // Next start clears fault.
    access(0, 16'h4000, 8'h00, 4'd8, 4'd0, 8'h00, 1, 8'h77, 0, 0);
    chk("fault_cleared", fault, 0);
    chk("load_r8", regs[8], 8'h77);

    // Pair r2:r3 = 0xFFFF, +1 wraps; bit0 of ptr_sel ignored.
    access(0, {regs[3], regs[2]}, 8'h00, 4'd9, 4'd3, 8'h01, 0, 8'h11, 0, 0);
    chk("load_r9", regs[9], 8'h11);
`ifdef POST_INC_EN
    chk("pair_wrap", {regs[3], regs[2]}, 16'h0000);
`else
    chk("pair_untouched", {regs[3], regs[2]}, 16'hFFFF);
`endif

    // Store with decrement.
    access(1, {regs[3], regs[2]}, 8'h99, 4'd0, 4'd2, 8'hFF, 2, 8'h00, 0, 0);
    chk("pair_dec", {regs[3], regs[2]}, 16'hFFFF);

    // Load into the pointer pair itself: write first, then add.
    access(0, {regs[11], regs[10]}, 8'h00, 4'd10, 4'd10, 8'h02, 0, 8'h30, 0, 0);
`ifdef POST_INC_EN
    chk("dst_in_pair_lo", regs[10], 8'h32);
`else
    chk("dst_in_pair_lo", regs[10], 8'h30);
`endif
    chk("dst_in_pair_hi", regs[11], 8'h20);

    // Ack in the timeout cycle wins.
    access(0, 16'h5555, 8'h00, 4'd12, 4'd0, 8'h00, TO - 1, 8'h5A, 0, 0);
    chk("late_ack_r12", regs[12], 8'h5A);
    chk("late_ack_fault", fault, 0);

    // Reset mid-REQ after an ignored second start.
    access(0, 16'hAAAA, 8'h00, 4'd13, 4'd0, 8'h00, -1, 8'h00, 2, 4);
    chk("post_reset_busy", busy, 0);

    access(1, 16'h0102, 8'hC3, 4'd0, 4'd0, 8'h00, 2, 8'h00, 0, 0);
    chk("post_reset_store_latency", last_done_cyc - p_s, 3);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
